// File: rtl/game_sequencer_if.sv
// Signal bundle between game_sequencer and its surroundings: synchronized
// buttons, frame timing and collision in; move strobes, ship reset and HUD state out.
interface game_sequencer_if;
  logic        frame_tick;
  logic        start_btn;
  logic        btn_left;
  logic        btn_right;
  logic        btn_up;
  logic        btn_down;
  logic        collision;
  logic        move_left;
  logic        move_right;
  logic        move_up;
  logic        move_down;
  logic        ship_reset;
  logic [1:0]  state;
  logic [1:0]  lives;
  logic [15:0] score;

  // Handshake: no valid/ready. All inputs are levels sampled on every rising
  // clk edge, except frame_tick, which is a single-cycle qualifier. All
  // outputs come from registers and change only on clk edges or on reset.
  modport slave (
    input  frame_tick, start_btn, btn_left, btn_right, btn_up, btn_down, collision,
    output move_left, move_right, move_up, move_down, ship_reset, state, lives, score
  );

  modport master (
    output frame_tick, start_btn, btn_left, btn_right, btn_up, btn_down, collision,
    input  move_left, move_right, move_up, move_down, ship_reset, state, lives, score
  );
endinterface

// File: rtl/game_sequencer.sv
// meteor_dodge game-flow controller: IDLE/PLAY/HIT/OVER sequencing, lives,
// frames-survived score and frame-paced, accelerating ship move strobes.
module game_sequencer #(
  parameter int LIVES_INIT  = 3,
  parameter int HIT_FRAMES  = 60,
  parameter int HOLD_FRAMES = 8,
  parameter int FAST_BURST  = 2
) (
  input logic              clk,
  input logic              reset,
  game_sequencer_if.slave  bus
);
  localparam int HCW  = $clog2(HOLD_FRAMES + 1);
  localparam int HITW = $clog2(HIT_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_HIT = 2'd2, S_OVER = 2'd3} state_t;
  // D_NEG is left/up, D_POS is right/down.
  typedef enum logic [1:0] {D_NONE = 2'd0, D_NEG = 2'd1, D_POS = 2'd2} dir_t;

  state_t          r_state, w_state_nxt;
  logic            r_start_q;
  logic            r_ship_reset;
  logic [1:0]      r_lives;
  logic [15:0]     r_score;
  logic [HITW-1:0] r_hit_cnt;
  logic [HCW-1:0]  r_hcnt, r_vcnt;
  dir_t            r_hprev, r_vprev, r_hsel, r_vsel;
  logic [2:0]      r_hburst, r_vburst;

  function automatic dir_t axis_dir(input logic neg, input logic pos);
    if (neg && !pos)      return D_NEG;
    else if (pos && !neg) return D_POS;
    else                  return D_NONE;
  endfunction

  function automatic logic [HCW-1:0] next_cnt(input dir_t d, input dir_t prev,
                                              input logic [HCW-1:0] cnt);
    if (d == D_NONE)                     return '0;
    else if (d != prev)                  return HCW'(1);
    else if (cnt >= HCW'(HOLD_FRAMES))   return HCW'(HOLD_FRAMES);
    else                                 return cnt + HCW'(1);
  endfunction

  logic           w_start_edge, w_hit_done;
  dir_t           w_hdir, w_vdir;
  logic [HCW-1:0] w_hcnt_nxt, w_vcnt_nxt;
  logic [2:0]     w_hlen, w_vlen;

  assign w_start_edge = bus.start_btn & ~r_start_q;
  assign w_hit_done   = bus.frame_tick && (r_hit_cnt == HITW'(HIT_FRAMES - 1));
  assign w_hdir       = axis_dir(bus.btn_left, bus.btn_right);
  assign w_vdir       = axis_dir(bus.btn_up, bus.btn_down);
  assign w_hcnt_nxt   = next_cnt(w_hdir, r_hprev, r_hcnt);
  assign w_vcnt_nxt   = next_cnt(w_vdir, r_vprev, r_vcnt);
  assign w_hlen = (w_hdir == D_NONE) ? 3'd0 :
                  (w_hcnt_nxt >= HCW'(HOLD_FRAMES)) ? 3'(FAST_BURST) : 3'd1;
  assign w_vlen = (w_vdir == D_NONE) ? 3'd0 :
                  (w_vcnt_nxt >= HCW'(HOLD_FRAMES)) ? 3'(FAST_BURST) : 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_edge) w_state_nxt = S_PLAY;
      S_PLAY: if (bus.collision) w_state_nxt = (r_lives == 2'd1) ? S_OVER : S_HIT;
      S_HIT:  if (w_hit_done) w_state_nxt = S_PLAY;
      S_OVER: if (w_start_edge) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q    <= 1'b1;
      r_ship_reset <= 1'b0;
      r_lives      <= '0;
      r_score      <= '0;
      r_hit_cnt    <= '0;
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_hprev      <= D_NONE;
      r_vprev      <= D_NONE;
      r_hsel       <= D_NONE;
      r_vsel       <= D_NONE;
      r_hburst     <= '0;
      r_vburst     <= '0;
    end else begin
      r_start_q    <= bus.start_btn;
      r_ship_reset <= 1'b0;
      if (r_hburst != 3'd0) r_hburst <= r_hburst - 3'd1;
      if (r_vburst != 3'd0) r_vburst <= r_vburst - 3'd1;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_lives      <= 2'(LIVES_INIT);
            r_score      <= '0;
            r_ship_reset <= 1'b1;
          end
        end
        S_PLAY: begin
          if (bus.frame_tick && r_score != 16'hFFFF) r_score <= r_score + 16'd1;
          // Collision outranks a coincident tick: no new strobe is launched.
          if (bus.collision) begin
            r_hburst  <= '0;
            r_vburst  <= '0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_hprev   <= D_NONE;
            r_vprev   <= D_NONE;
            r_lives   <= r_lives - 2'd1;
            r_hit_cnt <= '0;
          end else if (bus.frame_tick) begin
            r_hcnt   <= w_hcnt_nxt;
            r_vcnt   <= w_vcnt_nxt;
            r_hprev  <= w_hdir;
            r_vprev  <= w_vdir;
            r_hsel   <= w_hdir;
            r_vsel   <= w_vdir;
            r_hburst <= w_hlen;
            r_vburst <= w_vlen;
          end
        end
        S_HIT: begin
          if (w_hit_done)          r_ship_reset <= 1'b1;
          else if (bus.frame_tick) r_hit_cnt <= r_hit_cnt + HITW'(1);
        end
        S_OVER: r_lives <= '0;
        default: ;
      endcase
    end
  end

  assign bus.move_left  = (r_hburst != 3'd0) && (r_hsel == D_NEG);
  assign bus.move_right = (r_hburst != 3'd0) && (r_hsel == D_POS);
  assign bus.move_up    = (r_vburst != 3'd0) && (r_vsel == D_NEG);
  assign bus.move_down  = (r_vburst != 3'd0) && (r_vsel == D_POS);
  assign bus.ship_reset = r_ship_reset;
  assign bus.state      = r_state;
  assign bus.lives      = r_lives;
  assign bus.score      = r_score;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with default parameters.
module tb_game_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   len;

  game_sequencer_if bus();

  game_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic mv(input int sel);
    case (sel)
      0: return bus.move_left;
      1: return bus.move_right;
      2: return bus.move_up;
      default: return bus.move_down;
    endcase
  endfunction

  // Issue one tick, then count consecutive high cycles of the selected strobe.
  task automatic tick_measure(input int sel, output int n);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!mv(sel)) break;
      n++;
      step();
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_tick = 0; bus.start_btn = 0; bus.collision = 0;
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_up = 0; bus.btn_down = 0;
    repeat (3) step();
    check("rst_state", bus.state, 0);
    check("rst_lives", bus.lives, 0);
    check("rst_score", bus.score, 0);
    check("rst_ship_reset", bus.ship_reset, 0);
    check("rst_moves", {bus.move_left, bus.move_right, bus.move_up, bus.move_down}, 0);
    reset = 1'b0;
    repeat (7) step();

    // 1: start and first move
    bus.start_btn = 1'b1;
    step();
    check("t1_state_play", bus.state, 1);
    check("t1_ship_reset_hi", bus.ship_reset, 1);
    check("t1_lives", bus.lives, 3);
    check("t1_score", bus.score, 0);
    bus.start_btn = 1'b0;
    step();
    check("t1_ship_reset_lo", bus.ship_reset, 0);
    bus.btn_left = 1'b1;
    tick_measure(0, len);
    check("t1_left_len", len, 1);
    check("t1_score_after", bus.score, 1);

    // 2: acceleration after eight held frames
    bus.btn_left = 1'b0; bus.btn_right = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick_measure(1, len);
      check($sformatf("t2_right_len_%0d", i), len, (i >= 8) ? 2 : 1);
    end
    check("t2_score", bus.score, 11);
    bus.btn_right = 1'b0;
    tick_measure(1, len);
    check("t2_release_len", len, 0);
    bus.btn_right = 1'b1;
    tick_measure(1, len);
    check("t2_rehold_len", len, 1);
    check("t2_score_after", bus.score, 13);

    // 3: opposing vertical buttons cancel, horizontal still moves
    bus.btn_right = 1'b0;
    bus.btn_up = 1'b1; bus.btn_down = 1'b1; bus.btn_left = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    check("t3_left", bus.move_left, 1);
    check("t3_up_down", {bus.move_up, bus.move_down}, 0);
    step();
    check("t3_left_end", bus.move_left, 0);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0;

    // 4: collision in the first cycle of a fast burst
    bus.btn_right = 1'b1;
    for (int i = 1; i <= 7; i++) tick_measure(1, len);
    check("t4_pre_len", len, 1);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    check("t4_burst_start", bus.move_right, 1);
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    check("t4_right_dropped", bus.move_right, 0);
    check("t4_state_hit", bus.state, 2);
    check("t4_lives", bus.lives, 2);
    check("t4_score", bus.score, 22);
    tick_n(59);
    check("t4_still_hit", bus.state, 2);
    check("t4_score_frozen", bus.score, 22);
    check("t4_no_strobe_hit", bus.move_right, 0);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    check("t4_back_play", bus.state, 1);
    check("t4_ship_reset_hi", bus.ship_reset, 1);
    step();
    check("t4_ship_reset_lo", bus.ship_reset, 0);
    tick_measure(1, len);
    check("t4_slow_again", len, 1);
    check("t4_score_after", bus.score, 23);

    // 5: game over and restart
    bus.btn_right = 1'b0;
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    check("t5_hit2_lives", bus.lives, 1);
    tick_n(60);
    check("t5_play_again", bus.state, 1);
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    check("t5_over", bus.state, 3);
    check("t5_over_lives", bus.lives, 0);
    tick_n(2);
    check("t5_over_score", bus.score, 23);
    bus.start_btn = 1'b1;
    step();
    check("t5_idle", bus.state, 0);
    check("t5_idle_score", bus.score, 23);
    bus.start_btn = 1'b0;
    step();
    bus.start_btn = 1'b1;
    step();
    check("t5_restart_state", bus.state, 1);
    check("t5_restart_lives", bus.lives, 3);
    check("t5_restart_score", bus.score, 0);
    check("t5_restart_ship_reset", bus.ship_reset, 1);
    bus.start_btn = 1'b0;
    step();

    // 6: asynchronous reset mid-burst, start held through reset
    bus.btn_right = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    check("t6_burst_on", bus.move_right, 1);
    bus.start_btn = 1'b1;
    reset = 1'b1;
    #1;
    check("t6_async_moves", {bus.move_left, bus.move_right, bus.move_up, bus.move_down}, 0);
    check("t6_async_state", bus.state, 0);
    check("t6_async_lives", bus.lives, 0);
    step();
    reset = 1'b0;
    repeat (3) step();
    check("t6_held_no_start", bus.state, 0);
    bus.start_btn = 1'b0;
    step();
    bus.start_btn = 1'b1;
    step();
    check("t6_repress_start", bus.state, 1);
    bus.start_btn = 1'b0;
    step();
    bus.collision = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.collision = 1'b0;
    bus.frame_tick = 1'b0;
    check("t6_coll_tick_state", bus.state, 2);
    check("t6_coll_tick_score", bus.score, 1);
    check("t6_coll_tick_nostrobe", bus.move_right, 0);
    step();
    check("t6_coll_tick_nostrobe2", bus.move_right, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for meteor_dodge.
- Turns synchronized button levels into frame-paced move strobes for ship_controller.
- Runs the IDLE/PLAY/HIT/OVER state machine, tracks lives and a frames-survived score, and pulses the ship position reset.
- Sits between the input synchronizers / VGA frame timing and ship_controller, meteor logic and HUD.

Parameters:
LIVES_INIT, 3, lives loaded at game start (legal range 1..3).
HIT_FRAMES, 60, frame ticks spent frozen in HIT after a non-fatal collision (≥1).
HOLD_FRAMES, 8, consecutive held frames on one axis before fast movement begins (≥1).
FAST_BURST, 2, move-strobe length in cycles once fast (1..7); normal length is 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
frame_tick  in  1  one-cycle pulse, once per video frame
start_btn  in  1  synchronized start button level
btn_left, btn_right, btn_up, btn_down  in  1 each  synchronized direction levels
collision  in  1  ship/meteor overlap, sampled every cycle
move_left, move_right, move_up, move_down  out  1 each  registered strobes to ship_controller
ship_reset  out  1  one-cycle pulse that returns the ship to its start position
state  out  2  0=IDLE 1=PLAY 2=HIT 3=OVER
lives  out  2  remaining lives
score  out  16  frames survived in current game, saturating

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, lives=0, score=0.
  - All move_* and ship_reset =0.
  - Hold counters=0, burst counters=0.
  - Start-edge register start_q=1, so a button held through reset release does not start a game.
- start_edge = start_btn & ~start_q. start_q is registered every cycle.
- IDLE:
  - No strobes.
  - On start_edge: go to PLAY; lives=LIVES_INIT; score=0; ship_reset=1 for the next cycle only.
- PLAY:
  - On frame_tick: score+1, saturating at 16'hFFFF.
  - Each axis is evaluated independently on frame_tick.
    - Horizontal dir = left if btn_left&~btn_right; right if btn_right&~btn_left; else none. Vertical is the same with up/down.
    - Both buttons on one axis = none.
  - Per-axis hold counter, updated on frame_tick:
    - none → 0.
    - Same dir as previous tick → min(cnt+1, HOLD_FRAMES).
    - Changed dir → 1.
  - Burst length is FAST_BURST if the updated cnt ≥ HOLD_FRAMES, else 1. dir=none gives no burst.
  - Strobe timing: a tick sampled in cycle t asserts the chosen move_* in cycles t+1 .. t+len.
  - A frame_tick arriving during an active burst restarts the burst with the new dir and len.
  - Left and right are never both high; up and down are never both high.
  - Collision sampled high in cycle t:
    - All move_* are low from cycle t+1; active bursts are cancelled.
    - Hold counters clear.
    - If lives==1: lives=0, go to OVER.
    - Else: lives-1, go to HIT, frame counter=0.
  - Collision and frame_tick in the same cycle: collision wins. No strobe is issued; score still increments.
- HIT:
  - No strobes; collision ignored; score frozen.
  - Counts frame_ticks. On the tick that brings the count to HIT_FRAMES: go to PLAY; ship_reset=1 for the next cycle.
- OVER:
  - No strobes; lives=0; score held for display.
  - On start_edge: go to IDLE. score is retained until the next game start.
- ship_reset pulses only on the IDLE→PLAY and HIT→PLAY transitions, each exactly 1 cycle wide.
- start_btn is ignored in PLAY and HIT.

Test Plan:
1. Start and first move. Reset, then raise start_btn at cycle 10.
   - state=PLAY and ship_reset=1 for exactly one cycle; lives=3, score=0.
   - Hold btn_left and issue a frame_tick: move_left is high for exactly 1 cycle, one cycle after the tick.
2. Acceleration. Hold btn_right for 10 frame_ticks.
   - Ticks 1-7 give 1-cycle move_right strobes; ticks 8-10 give 2-cycle strobes.
   - Release for one tick and hold again: the next strobe is 1 cycle.
3. Opposing buttons and both axes. btn_up+btn_down+btn_left held on a tick.
   - move_left pulses; move_up and move_down stay 0; vertical hold counter=0.
4. Collision mid-burst. Fast right burst; collision in the burst's first cycle.
   - move_right drops the next cycle; state=HIT, lives=2.
   - After 60 frame_ticks: PLAY plus a one-cycle ship_reset. Movement is 1-cycle again, since the hold counter was cleared.
5. Game over and restart.
   - Three collisions: OVER with lives=0 and score frozen.
   - start edge → IDLE, score retained.
   - start edge → PLAY, lives=3, score=0.
6. Reset and edge cases.
   - Assert reset mid-burst in PLAY: all outputs go 0 immediately, state=IDLE.
   - start_btn held through reset release does not start a game; releasing and re-pressing does.
   - collision+frame_tick in the same cycle: no strobe, score+1, state=HIT.
